// File: rtl/game_ctrl.sv
// Game sequencer: TITLE/PLAY/PAUSE/OVER state machine with round timer, life counters and
// winner decision, feeding the VGA renderer's state word.
module game_ctrl #(
  parameter int unsigned FRAMES_PER_SEC = 60,
  parameter int unsigned ROUND_SEC      = 99,
  parameter int unsigned TIMER_W        = 7,
  parameter int unsigned START_LIVES    = 3,
  parameter int unsigned LIVES_W        = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_start,
  input  logic               i_pause,
  input  logic               i_frame_tick,
  input  logic               i_hit_p1,
  input  logic               i_hit_p2,
  output logic [1:0]         o_state,
  output logic               o_game_en,
  output logic [TIMER_W-1:0] o_timer,
  output logic [LIVES_W-1:0] o_p1_lives,
  output logic [LIVES_W-1:0] o_p2_lives,
  output logic [1:0]         o_winner
);

  localparam int unsigned FrameW = (FRAMES_PER_SEC > 1) ? $clog2(FRAMES_PER_SEC) : 1;
  localparam logic [FrameW-1:0]  FrameLast = FrameW'(FRAMES_PER_SEC - 1);
  localparam logic [TIMER_W-1:0] TimerInit = TIMER_W'(ROUND_SEC);
  localparam logic [LIVES_W-1:0] LivesInit = LIVES_W'(START_LIVES);

  typedef enum logic [1:0] {
    StTitle = 2'b00,
    StPlay  = 2'b01,
    StPause = 2'b10,
    StOver  = 2'b11
  } state_e;

  localparam logic [1:0] WinNone = 2'b00;
  localparam logic [1:0] WinP1   = 2'b01;
  localparam logic [1:0] WinP2   = 2'b10;
  localparam logic [1:0] WinDraw = 2'b11;

  state_e             state_q, state_d;
  logic               game_en_q, game_en_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [LIVES_W-1:0] p1_q, p1_d, p2_q, p2_d;
  logic [1:0]         winner_q, winner_d;
  logic [FrameW-1:0]  frame_q, frame_d;
  logic               start_prev_q, pause_prev_q;

  logic               start_e, pause_e;
  logic [LIVES_W-1:0] p1_play, p2_play;
  logic [TIMER_W-1:0] timer_play;
  logic [FrameW-1:0]  frame_play;

  assign start_e = i_start & ~start_prev_q;
  assign pause_e = i_pause & ~pause_prev_q;

  // Post-update PLAY values; the end-of-round decision looks at these, not the old state.
  always_comb begin
    p1_play    = p1_q;
    p2_play    = p2_q;
    timer_play = timer_q;
    frame_play = frame_q;
    if (i_hit_p1 && (p1_q != '0)) p1_play = p1_q - 1'b1;
    if (i_hit_p2 && (p2_q != '0)) p2_play = p2_q - 1'b1;
    if (i_frame_tick) begin
      if (frame_q == FrameLast) begin
        frame_play = '0;
        if (timer_q != '0) timer_play = timer_q - 1'b1;
      end else begin
        frame_play = frame_q + 1'b1;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    p1_d     = p1_q;
    p2_d     = p2_q;
    winner_d = winner_q;
    frame_d  = frame_q;
    unique case (state_q)
      StTitle: begin
        if (start_e) begin
          state_d  = StPlay;
          timer_d  = TimerInit;
          p1_d     = LivesInit;
          p2_d     = LivesInit;
          frame_d  = '0;
          winner_d = WinNone;
        end
      end
      StPlay: begin
        timer_d = timer_play;
        p1_d    = p1_play;
        p2_d    = p2_play;
        frame_d = frame_play;
        if ((p1_play == '0) && (p2_play == '0)) begin
          state_d  = StOver;
          winner_d = WinDraw;
        end else if (p1_play == '0) begin
          state_d  = StOver;
          winner_d = WinP2;
        end else if (p2_play == '0) begin
          state_d  = StOver;
          winner_d = WinP1;
        end else if (timer_play == '0) begin
          state_d = StOver;
          if (p1_play > p2_play)      winner_d = WinP1;
          else if (p2_play > p1_play) winner_d = WinP2;
          else                        winner_d = WinDraw;
        end else if (pause_e) begin
          state_d = StPause;
        end
      end
      StPause: begin
        if (pause_e) state_d = StPlay;
      end
      StOver: begin
        if (start_e) state_d = StTitle;
      end
      default: state_d = StTitle;
    endcase
    game_en_d = (state_d == StPlay);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StTitle;
      game_en_q    <= 1'b0;
      timer_q      <= TimerInit;
      p1_q         <= LivesInit;
      p2_q         <= LivesInit;
      winner_q     <= WinNone;
      frame_q      <= '0;
      start_prev_q <= 1'b1;
      pause_prev_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      game_en_q    <= game_en_d;
      timer_q      <= timer_d;
      p1_q         <= p1_d;
      p2_q         <= p2_d;
      winner_q     <= winner_d;
      frame_q      <= frame_d;
      start_prev_q <= i_start;
      pause_prev_q <= i_pause;
    end
  end

  assign o_state    = state_q;
  assign o_game_en  = game_en_q;
  assign o_timer    = timer_q;
  assign o_p1_lives = p1_q;
  assign o_p2_lives = p2_q;
  assign o_winner   = winner_q;

endmodule
